// File: rtl/imem_loader_pkg.sv
// Shared constants for the instruction-memory loader: state encoding and the
// word/address widths used by the PC and instruction memory.
package imem_loader_pkg;

  localparam int WORD_W = 32;
  localparam int ADDR_W = 64;
  localparam int BYTE_W = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // The CPU must stay frozen while bytes are arriving or a word is being written.
  function automatic logic is_busy(input logic [1:0] st);
    return (st == ST_LOAD) || (st == ST_WRITE);
  endfunction

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// Packs a little-endian byte stream into 32-bit words; the first byte of a
// word ends up in bits [7:0] once four bytes have been shifted in.
module byte_assembler
  import imem_loader_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [BYTE_W-1:0] stream_byte,
  input  logic              shift,
  input  logic              clear,
  output logic [WORD_W-1:0] word,
  output logic [1:0]        index,
  output logic              last
);

  // Shifting right from the top lands byte 0 in the low lane after four shifts,
  // and the 2-bit index wraps back to 0 on its own at the end of a word.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      word  <= '0;
      index <= '0;
    end else if (clear) begin
      word  <= '0;
      index <= '0;
    end else if (shift) begin
      word  <= {stream_byte, word[WORD_W-1:BYTE_W]};
      index <= index + 2'd1;
    end
  end

  assign last = (index == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Writer side of the instruction memory: collects a program byte stream into
// instruction words, writes them out one by one, and holds the CPU meanwhile.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned       NUM_WORDS = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 64'h0
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Abort,
  input  logic [BYTE_W-1:0] ByteIn,
  input  logic              ByteValid,
  output logic              ByteReady,
  output logic              WrEn,
  output logic [ADDR_W-1:0] WrAddr,
  output logic [WORD_W-1:0] WrData,
  output logic [15:0]       WordCount,
  output logic              CpuHold,
  output logic              Done
);

  logic [1:0]  state;
  logic [1:0]  state_next;
  logic        launch;
  logic        accept;
  logic        discard;
  logic        last;
  logic [1:0]  byte_index;
  logic [16:0] count_next;

  assign launch     = ((state == ST_IDLE) || (state == ST_DONE)) && Start;
  assign accept     = (state == ST_LOAD) && ByteValid && !Abort;
  assign discard    = (state == ST_LOAD) && Abort && (byte_index != 2'd0);
  assign count_next = {1'b0, WordCount} + 17'd1;

  byte_assembler u_assembler (
    .clock       (Clock),
    .reset       (Reset),
    .stream_byte (ByteIn),
    .shift       (accept),
    .clear       (launch || discard),
    .word        (WrData),
    .index       (byte_index),
    .last        (last)
  );

  // Abort beats every other transition out of LOAD and WRITE.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_DONE: if (Start) state_next = ST_LOAD;
      ST_LOAD: begin
        if (Abort)
          state_next = ST_IDLE;
        else if (accept && last)
          state_next = ST_WRITE;
      end
      ST_WRITE: begin
        if (Abort)
          state_next = ST_IDLE;
        else if (count_next == 17'(NUM_WORDS))
          state_next = ST_DONE;
        else
          state_next = ST_LOAD;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // The word strobed during WRITE is captured by memory, so it is always counted,
  // even if an abort arrives in that same cycle.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state     <= ST_IDLE;
      WrAddr    <= BASE_ADDR;
      WordCount <= '0;
    end else begin
      state <= state_next;
      if (launch) begin
        WrAddr    <= BASE_ADDR;
        WordCount <= '0;
      end else if (state == ST_WRITE) begin
        WrAddr    <= WrAddr + 64'd4;
        WordCount <= count_next[15:0];
      end
    end
  end

  assign ByteReady = (state == ST_LOAD);
  assign WrEn      = (state == ST_WRITE);
  assign CpuHold   = is_busy(state);
  assign Done      = (state == ST_DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: three instances with different sizes/bases share one
// stimulus stream and are compared every cycle against a byte-level model.
module tb_imem_loader;

  localparam int          NW0   = 2;
  localparam int          NW1   = 4;
  localparam int          NW2   = 2;
  localparam logic [63:0] BASE0 = 64'h0;
  localparam logic [63:0] BASE1 = 64'h0;
  localparam logic [63:0] BASE2 = 64'hFFFF_FFFF_FFFF_FFFC;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       Start = 1'b0;
  logic       Abort = 1'b0;
  logic       ByteValid = 1'b0;
  logic [7:0] ByteIn = 8'h00;

  logic [2:0]  ready, wren, hold, done_o;
  logic [63:0] addr [3];
  logic [31:0] data [3];
  logic [15:0] cnt  [3];

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  logic [95:0] wq0[$];
  logic [95:0] wq1[$];
  logic [95:0] wq2[$];

  // Model: per instance, whether a load is running, whether this is the write
  // cycle, bytes collected so far, the word being built, words written, address.
  bit          m_busy [3];
  bit          m_wr   [3];
  bit          m_done [3];
  int          m_n    [3];
  logic [31:0] m_word [3];
  int          m_cnt  [3];
  logic [63:0] m_addr [3];

  always #5 Clock = ~Clock;

  imem_loader #(.NUM_WORDS(NW0), .BASE_ADDR(BASE0)) u0 (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Abort(Abort), .ByteIn(ByteIn),
    .ByteValid(ByteValid), .ByteReady(ready[0]), .WrEn(wren[0]), .WrAddr(addr[0]),
    .WrData(data[0]), .WordCount(cnt[0]), .CpuHold(hold[0]), .Done(done_o[0]));

  imem_loader #(.NUM_WORDS(NW1), .BASE_ADDR(BASE1)) u1 (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Abort(Abort), .ByteIn(ByteIn),
    .ByteValid(ByteValid), .ByteReady(ready[1]), .WrEn(wren[1]), .WrAddr(addr[1]),
    .WrData(data[1]), .WordCount(cnt[1]), .CpuHold(hold[1]), .Done(done_o[1]));

  imem_loader #(.NUM_WORDS(NW2), .BASE_ADDR(BASE2)) u2 (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Abort(Abort), .ByteIn(ByteIn),
    .ByteValid(ByteValid), .ByteReady(ready[2]), .WrEn(wren[2]), .WrAddr(addr[2]),
    .WrData(data[2]), .WordCount(cnt[2]), .CpuHold(hold[2]), .Done(done_o[2]));

  function automatic int nw_of(input int i);
    return (i == 0) ? NW0 : (i == 1) ? NW1 : NW2;
  endfunction

  function automatic logic [63:0] base_of(input int i);
    return (i == 0) ? BASE0 : (i == 1) ? BASE1 : BASE2;
  endfunction

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40)
        $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_busy[i] = 1'b0;
      m_wr[i]   = 1'b0;
      m_done[i] = 1'b0;
      m_n[i]    = 0;
      m_word[i] = '0;
      m_cnt[i]  = 0;
      m_addr[i] = base_of(i);
    end
  endtask

  task automatic model_step(input int i);
    if (m_busy[i]) begin
      if (m_wr[i]) begin
        m_wr[i]   = 1'b0;
        m_cnt[i]  = m_cnt[i] + 1;
        m_addr[i] = m_addr[i] + 64'd4;
        m_n[i]    = 0;
        if (Abort) begin
          m_busy[i] = 1'b0;
        end else if (m_cnt[i] == nw_of(i)) begin
          m_busy[i] = 1'b0;
          m_done[i] = 1'b1;
        end
      end else if (Abort) begin
        m_busy[i] = 1'b0;
        m_n[i]    = 0;
      end else if (ByteValid) begin
        m_word[i][8*m_n[i] +: 8] = ByteIn;
        m_n[i] = m_n[i] + 1;
        if (m_n[i] == 4) m_wr[i] = 1'b1;
      end
    end else if (Start) begin
      m_busy[i] = 1'b1;
      m_done[i] = 1'b0;
      m_cnt[i]  = 0;
      m_addr[i] = base_of(i);
      m_n[i]    = 0;
    end
  endtask

  always @(posedge Clock) begin
    if (!Reset)
      for (int i = 0; i < 3; i++) model_step(i);
  end

  // Mid-cycle compare of every instance against the model, plus a log of writes.
  always @(negedge Clock) begin
    if (!Reset && chk_en) begin
      for (int i = 0; i < 3; i++) begin
        check_output($sformatf("u%0d ByteReady", i), ready[i], m_busy[i] && !m_wr[i]);
        check_output($sformatf("u%0d WrEn", i), wren[i], m_wr[i]);
        check_output($sformatf("u%0d CpuHold", i), hold[i], m_busy[i]);
        check_output($sformatf("u%0d Done", i), done_o[i], m_done[i]);
        check_output($sformatf("u%0d WordCount", i), cnt[i], 16'(m_cnt[i]));
        check_output($sformatf("u%0d WrAddr", i), addr[i], m_addr[i]);
        if (m_wr[i])
          check_output($sformatf("u%0d WrData", i), data[i], m_word[i]);
      end
      if (wren[0]) wq0.push_back({addr[0], data[0]});
      if (wren[1]) wq1.push_back({addr[1], data[1]});
      if (wren[2]) wq2.push_back({addr[2], data[2]});
    end
  end

  task automatic next_cycle();
    @(negedge Clock);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) next_cycle();
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    next_cycle();
    Start = 1'b0;
  endtask

  task automatic pulse_abort();
    Abort = 1'b1;
    next_cycle();
    Abort = 1'b0;
  endtask

  task automatic clear_queues();
    wq0.delete();
    wq1.delete();
    wq2.delete();
  endtask

  // Present one byte and hold it until u0 accepts it, then idle for 'gap' cycles.
  task automatic apply_stimulus(input logic [7:0] b, input int gap);
    bit taken;
    taken = 1'b0;
    ByteIn = b;
    ByteValid = 1'b1;
    for (int k = 0; k < 100 && !taken; k++) begin
      taken = ready[0];
      next_cycle();
    end
    if (!taken) begin
      tests++;
      fails++;
      $display("[TB] FAIL byte handshake: got no ByteReady, expected one within 100 cycles");
    end
    ByteValid = 1'b0;
    idle_cycles(gap);
  endtask

  task automatic send_program(input int gap, input bit poke_start);
    logic [7:0] prog [8];
    prog = '{8'h00, 8'h00, 8'h1F, 8'hD6, 8'hE0, 8'h03, 8'h1F, 8'hAA};
    for (int k = 0; k < 8; k++) begin
      apply_stimulus(prog[k], gap);
      if (poke_start && k == 2) pulse_start();
    end
  endtask

  task automatic check_program_writes();
    check_output("u0 write count", wq0.size(), 2);
    if (wq0.size() >= 2) begin
      check_output("u0 w0 addr", wq0[0][95:32], 64'h0);
      check_output("u0 w0 data", wq0[0][31:0], 32'hD61F0000);
      check_output("u0 w1 addr", wq0[1][95:32], 64'h4);
      check_output("u0 w1 data", wq0[1][31:0], 32'hAA1F03E0);
    end
  endtask

  initial begin
    model_reset();
    #12;
    for (int i = 0; i < 3; i++) begin
      check_output($sformatf("rst u%0d ByteReady", i), ready[i], 0);
      check_output($sformatf("rst u%0d WrEn", i), wren[i], 0);
      check_output($sformatf("rst u%0d CpuHold", i), hold[i], 0);
      check_output($sformatf("rst u%0d Done", i), done_o[i], 0);
      check_output($sformatf("rst u%0d WrData", i), data[i], 0);
      check_output($sformatf("rst u%0d WordCount", i), cnt[i], 0);
    end
    check_output("rst u0 WrAddr", addr[0], 64'h0);
    check_output("rst u2 WrAddr", addr[2], 64'hFFFF_FFFF_FFFF_FFFC);
    next_cycle();
    Reset = 1'b0;
    chk_en = 1'b1;

    // Asynchronous reset in the middle of a word must drop the partial bytes.
    pulse_start();
    apply_stimulus(8'hA5, 0);
    apply_stimulus(8'h5A, 0);
    #2 Reset = 1'b1;
    #1;
    check_output("midrst ByteReady", ready[0], 0);
    check_output("midrst CpuHold", hold[0], 0);
    check_output("midrst WrData", data[0], 0);
    check_output("midrst WordCount", cnt[0], 0);
    check_output("midrst WrAddr", addr[0], 64'h0);
    model_reset();
    next_cycle();
    Reset = 1'b0;
    clear_queues();
    pulse_start();
    apply_stimulus(8'h11, 0);
    apply_stimulus(8'h22, 0);
    apply_stimulus(8'h33, 0);
    apply_stimulus(8'h44, 0);
    idle_cycles(2);
    check_output("postrst write count", wq0.size(), 1);
    if (wq0.size() >= 1) begin
      check_output("postrst addr", wq0[0][95:32], 64'h0);
      check_output("postrst data", wq0[0][31:0], 32'h44332211);
    end
    pulse_abort();

    // Back-to-back program with ByteValid held high.
    clear_queues();
    pulse_start();
    send_program(0, 1'b0);
    idle_cycles(2);
    check_program_writes();
    check_output("prog Done", done_o[0], 1);
    check_output("prog CpuHold", hold[0], 0);
    check_output("prog WordCount", cnt[0], 2);
    check_output("wrap write count", wq2.size(), 2);
    if (wq2.size() >= 2) begin
      check_output("wrap w0 addr", wq2[0][95:32], 64'hFFFF_FFFF_FFFF_FFFC);
      check_output("wrap w1 addr", wq2[1][95:32], 64'h0);
      check_output("wrap w1 data", wq2[1][31:0], 32'hAA1F03E0);
    end
    pulse_abort();

    // Abort after six bytes on the four-word instance.
    clear_queues();
    pulse_start();
    for (int k = 0; k < 6; k++) apply_stimulus(8'(8'h30 + k), 0);
    pulse_abort();
    check_output("abort u1 writes", wq1.size(), 1);
    if (wq1.size() >= 1) begin
      check_output("abort u1 addr", wq1[0][95:32], 64'h0);
      check_output("abort u1 data", wq1[0][31:0], 32'h33323130);
    end
    check_output("abort u1 WordCount", cnt[1], 1);
    check_output("abort u1 CpuHold", hold[1], 0);
    check_output("abort u1 Done", done_o[1], 0);
    check_output("abort u1 ByteReady", ready[1], 0);

    // Sparse ByteValid plus a Start that lands mid-load.
    clear_queues();
    pulse_start();
    send_program(2, 1'b1);
    idle_cycles(2);
    check_program_writes();

    // Start from DONE restarts the load.
    pulse_start();
    check_output("restart Done", done_o[0], 0);
    check_output("restart WordCount", cnt[0], 0);
    check_output("restart WrAddr", addr[0], 64'h0);
    check_output("restart CpuHold", hold[0], 1);
    for (int k = 0; k < 8; k++) apply_stimulus(8'($urandom), 0);
    for (int k = 0; k < 20 && !done_o[0]; k++) next_cycle();
    check_output("restart completes", done_o[0], 1);
    pulse_abort();

    // Random traffic; the compare process does all the checking.
    for (int k = 0; k < 3000; k++) begin
      ByteValid = ($urandom_range(0, 9) < 6);
      ByteIn    = 8'($urandom);
      Start     = ($urandom_range(0, 19) == 0);
      Abort     = ($urandom_range(0, 99) == 0);
      next_cycle();
    end
    ByteValid = 1'b0;
    Start = 1'b0;
    Abort = 1'b0;
    idle_cycles(10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
